// File: rtl/mac_tx_framer_pkg.sv
// mac_tx_framer_pkg: state encoding, frame constants and keep helpers
// shared by the Ethernet TX framer.
// Optional feature macro: MAC_TX_PAD_EN (adds the PAD state for
// padding short frames up to the minimum frame length).
package mac_tx_framer_pkg;

    localparam int HDR_LEN       = 14;  // dst(6) + src(6) + ethertype(2)
    localparam int MIN_FRAME_LEN = 60;  // minimum frame length without FCS
    localparam int BEAT_BYTES    = 8;   // bytes per 64-bit beat

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_TAIL = 3'd4
`ifdef MAC_TX_PAD_EN
        ,
        ST_PAD  = 3'd5
`endif
    } state_t;

    // Debug view of the framer FSM, visible for probing.
    typedef struct packed {
        state_t      state;
        logic [15:0] byte_cnt;
    } fsm_dbg_t;

    // Number of bytes in an MSB-first keep: length of the leading run of
    // ones, so a malformed keep still yields a well-defined count.
    function automatic logic [3:0] keep_to_count(input logic [7:0] keep);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            run = run & keep[i];
            if (run) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // MSB-contiguous keep carrying n bytes (n in 0..8).
    function automatic logic [7:0] count_to_keep(input logic [3:0] n);
        logic [7:0] k;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) begin
                k[7-i] = 1'b1;
            end
        end
        return k;
    endfunction

    // Expand a keep vector into a 64-bit byte mask.
    function automatic logic [63:0] keep_to_mask(input logic [7:0] keep);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: prepends the 14-byte Ethernet header {dst, src, type}
// to a 64-bit AXI-Stream payload and realigns the payload by 6 bytes.
// Optional feature macro: MAC_TX_PAD_EN -- short frames are zero-padded
// to 60 bytes through an extra PAD state.
//
// Handshake: a beat moves on either stream only in a cycle where both
// valid and ready are high. The output register advances when it is
// empty or its beat is being accepted (advance); while a beat is stalled
// every m_axis_mac_* signal holds. s_axis_ready is only offered in
// states that consume payload and never depends on s_axis_valid.
module mac_tx_framer
    import mac_tx_framer_pkg::*;
#(
    parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_dymanic_src_mac,
    input  logic        i_src_mac_valid,
    input  logic [63:0] s_axis_data,
    input  logic [79:0] s_axis_user,
    input  logic [7:0]  s_axis_keep,
    input  logic        s_axis_last,
    input  logic        s_axis_valid,
    output logic        s_axis_ready,
    output logic [63:0] m_axis_mac_data,
    output logic [7:0]  m_axis_mac_keep,
    output logic        m_axis_mac_last,
    output logic        m_axis_mac_valid,
    input  logic        m_axis_mac_ready
);

    // Header bytes left over after HDR0; the same 6 bytes of each
    // consumed payload beat carry over into the following output beat.
    localparam logic [3:0]  CARRY_BYTES = 4'(HDR_LEN - BEAT_BYTES);
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] BEAT_LEN    = 16'(BEAT_BYTES);

    state_t      state_q, state_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [47:0] hdr_dst_q, hdr_dst_d;
    logic [47:0] hdr_src_q, hdr_src_d;
    logic [15:0] hdr_type_q, hdr_type_d;
    logic [63:0] prev_q, prev_d;
    logic [3:0]  prev_n_q, prev_n_d;
    logic [15:0] cnt_q, cnt_d;

    logic [63:0] data_q, data_d;
    logic [7:0]  keep_q, keep_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        take;
    logic [3:0]  in_n;

    logic        emit;
    logic        e_final;
    logic        is_last;
    state_t      e_next;
    logic [63:0] e_data;
    logic [3:0]  e_bytes;
    logic [3:0]  o_bytes;

    fsm_dbg_t    fsm_dbg;
    logic        unused_sink;

    // Output-stage flow control and payload acceptance.
    always_comb begin
        advance      = ~valid_q | m_axis_mac_ready;
        s_axis_ready = advance & ((state_q == ST_HDR1) | (state_q == ST_DATA));
        take         = s_axis_ready & s_axis_valid;
        in_n         = keep_to_count(s_axis_keep);
    end

    // Runtime source MAC: takes effect at the next frame's header latch.
    always_comb begin
        src_mac_d = src_mac_q;
        if (i_src_mac_valid) begin
            src_mac_d = i_dymanic_src_mac;
        end
    end

    // Next-state logic and construction of the next output beat.
    always_comb begin
        state_d    = state_q;
        hdr_dst_d  = hdr_dst_q;
        hdr_src_d  = hdr_src_q;
        hdr_type_d = hdr_type_q;
        prev_d     = prev_q;
        prev_n_d   = prev_n_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        valid_d    = valid_q;
        emit       = 1'b0;
        e_final    = 1'b0;
        e_next     = state_q;
        e_data     = '0;
        e_bytes    = 4'd0;

        case (state_q)
            ST_IDLE: begin
                // Header fields are captured with the first beat still
                // pending; that beat is consumed in HDR1.
                if (s_axis_valid) begin
                    hdr_dst_d  = s_axis_user[63:16];
                    hdr_type_d = s_axis_user[15:0];
                    hdr_src_d  = src_mac_q;
                    state_d    = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (advance) begin
                    emit    = 1'b1;
                    e_data  = {hdr_dst_q, hdr_src_q[47:32]};
                    e_bytes = BEAT_LEN[3:0];
                    e_next  = ST_HDR1;
                end
            end
            ST_HDR1, ST_DATA: begin
                if (take) begin
                    emit     = 1'b1;
                    e_data   = (state_q == ST_HDR1) ?
                               {hdr_src_q[31:0], hdr_type_q, s_axis_data[63:48]} :
                               {prev_q[47:0], s_axis_data[63:48]};
                    prev_d   = s_axis_data;
                    prev_n_d = in_n;
                    if (!s_axis_last) begin
                        e_bytes = BEAT_LEN[3:0];
                        e_next  = ST_DATA;
                    end else if (in_n <= 4'd2) begin
                        e_bytes = CARRY_BYTES + in_n;
                        e_final = 1'b1;
                    end else begin
                        e_bytes = BEAT_LEN[3:0];
                        e_next  = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (advance) begin
                    emit    = 1'b1;
                    e_data  = {prev_q[47:0], 16'h0000};
                    e_bytes = prev_n_q - 4'd2;
                    e_final = 1'b1;
                end
            end
`ifdef MAC_TX_PAD_EN
            ST_PAD: begin
                // Pure fill beats: no real bytes, padding decides length.
                if (advance) begin
                    emit    = 1'b1;
                    e_bytes = 4'd0;
                    e_final = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        o_bytes = e_bytes;
        is_last = e_final;
`ifdef MAC_TX_PAD_EN
        // A frame ending short of the minimum is stretched with zeros;
        // the last beat always lands on the 60-byte boundary.
        if (e_final && ((cnt_q + 16'(e_bytes)) < MIN_LEN)) begin
            if ((cnt_q + BEAT_LEN) >= MIN_LEN) begin
                o_bytes = 4'(MIN_LEN - cnt_q);
            end else begin
                o_bytes = BEAT_LEN[3:0];
                is_last = 1'b0;
                e_next  = ST_PAD;
            end
        end
`endif

        if (emit) begin
            // Bytes past the real content are forced to zero.
            data_d  = e_data & keep_to_mask(count_to_keep(e_bytes));
            keep_d  = count_to_keep(o_bytes);
            last_d  = is_last;
            valid_d = 1'b1;
            cnt_d   = is_last ? 16'd0 : (cnt_q + 16'(o_bytes));
            state_d = is_last ? ST_IDLE : e_next;
        end else if (advance) begin
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    // FSM state and emitted-byte counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Source MAC register and per-frame header latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_mac_q  <= P_SRC_MAC_ADDR;
            hdr_dst_q  <= '0;
            hdr_src_q  <= '0;
            hdr_type_q <= '0;
        end else begin
            src_mac_q  <= src_mac_d;
            hdr_dst_q  <= hdr_dst_d;
            hdr_src_q  <= hdr_src_d;
            hdr_type_q <= hdr_type_d;
        end
    end

    // Previously consumed payload beat and its byte count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q   <= '0;
            prev_n_q <= '0;
        end else begin
            prev_q   <= prev_d;
            prev_n_q <= prev_n_d;
        end
    end

    // Output register stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_mac_data  = data_q;
    assign m_axis_mac_keep  = keep_q;
    assign m_axis_mac_last  = last_q;
    assign m_axis_mac_valid = valid_q;

    // Debug view for probes; the length field is not used for framing.
    assign fsm_dbg     = {state_q, cnt_q};
    assign unused_sink = ^{s_axis_user[79:64], fsm_dbg};

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: directed and randomized frames for mac_tx_framer,
// checked beat by beat against a byte-level frame model.
`timescale 1ns/1ps
module tb_mac_tx_framer;
    import mac_tx_framer_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [47:0] dyn_mac = '0;
    logic        src_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic [79:0] s_user = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b1;

    mac_tx_framer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_dymanic_src_mac(dyn_mac),
        .i_src_mac_valid  (src_valid),
        .s_axis_data      (s_data),
        .s_axis_user      (s_user),
        .s_axis_keep      (s_keep),
        .s_axis_last      (s_last),
        .s_axis_valid     (s_valid),
        .s_axis_ready     (s_ready),
        .m_axis_mac_data  (m_data),
        .m_axis_mac_keep  (m_keep),
        .m_axis_mac_last  (m_last),
        .m_axis_mac_valid (m_valid),
        .m_axis_mac_ready (m_ready)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b1;
    bit          lat_arm = 1'b0;
    int          lat_cyc = 0;
    logic [47:0] exp_src = 48'h01_02_03_04_05_06;

    // Scoreboard
    logic [63:0] exp_data_q[$];
    logic [7:0]  exp_keep_q[$];
    logic        exp_last_q[$];
    int          exp_len_q[$];
    logic [7:0]  pay_q[$];

    int          cur_beats = 0;
    int          cur_bytes = 0;
    logic [63:0] cur_beat0 = '0;
    int          cap_beats = 0;
    int          cap_bytes = 0;
    logic [63:0] cap_beat0 = '0;
    logic [7:0]  cap_last_keep = '0;
    bit          hold_pend = 1'b0;
    logic [63:0] hold_data = '0;
    logic [9:0]  hold_ctl = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lead_ones(input logic [7:0] k);
        int n;
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            if (k[i] == 1'b0) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] rand_keep();
        int n;
        logic [7:0] k;
        n = $urandom_range(1, 8);
        k = 8'hFF << (8 - n);
        if (n < 7 && $urandom_range(0, 1) == 1) begin
            k = k | (8'($urandom_range(0, 255)) & (8'hFF >> (n + 1)));
        end
        return k;
    endfunction

    // Frame model: header + payload bytes (+ zero pad), cut into beats.
    task automatic push_expected(input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] etype);
        logic [7:0]  fb[$];
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
        fb.push_back(etype[15:8]);
        fb.push_back(etype[7:0]);
        foreach (pay_q[i]) fb.push_back(pay_q[i]);
`ifdef MAC_TX_PAD_EN
        while (fb.size() < 60) fb.push_back(8'h00);
`endif
        for (int i = 0; i < fb.size(); i += 8) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < fb.size()) begin
                    d[63-8*j -: 8] = fb[i+j];
                    k[7-j] = 1'b1;
                end
            end
            exp_data_q.push_back(d);
            exp_keep_q.push_back(k);
            exp_last_q.push_back(i + 8 >= fb.size());
        end
        exp_len_q.push_back(fb.size());
    endtask

    // Driver: sends pay_q as one frame; optional MAC pulse after a beat.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                              input int nbeats, input logic [7:0] lkeep,
                              input int pulse_beat, input logic [47:0] pulse_mac,
                              input bit gaps, input bit arm_lat);
        int          n;
        int          idx;
        int          t;
        bit          acc;
        logic [63:0] d;
        n = lead_ones(lkeep);
        push_expected(dst, exp_src, etype);
        idx = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge i_clk); #1;
            end
            d = '0;
            for (int j = 0; j < 8; j++) begin
                if (b < nbeats - 1 || j < n) begin
                    d[63-8*j -: 8] = pay_q[idx];
                    idx++;
                end
            end
            s_data  = d;
            s_keep  = (b == nbeats - 1) ? lkeep : 8'hFF;
            s_last  = (b == nbeats - 1);
            s_user  = {16'(pay_q.size()), dst, etype};
            s_valid = 1'b1;
            if (b == 0 && arm_lat) begin
                lat_cyc = 0;
                lat_arm = 1'b1;
            end
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge i_clk);
                acc = s_ready;
                @(posedge i_clk); #1;
                t++;
            end
            chk("beat_accepted", 64'(acc), 64'd1);
            if (b == pulse_beat) begin
                s_valid   = 1'b0;
                src_valid = 1'b1;
                dyn_mac   = pulse_mac;
                @(posedge i_clk); #1;
                src_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        pay_q.delete();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_data_q.size() != 0 || m_valid) && t < 3000) begin
            @(posedge i_clk); #1;
            t++;
        end
        chk("drain", 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic fill_payload(input int nbytes);
        for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Downstream ready: always-on or 50% random.
    always @(posedge i_clk) begin
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else               m_ready = 1'($urandom_range(0, 1));
    end

    always @(posedge i_clk) begin
        if (lat_arm) lat_cyc++;
    end

    // Monitor / scoreboard compare, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst || !mon_en) begin
            hold_pend = 1'b0;
            cur_beats = 0;
            cur_bytes = 0;
        end else begin
            if (hold_pend) begin
                chk("stall_data", m_data, hold_data);
                chk("stall_ctl", 64'({m_keep, m_last, m_valid}), 64'(hold_ctl));
            end
            if (lat_arm && m_valid) begin
                chk("latency", 64'(lat_cyc), 64'd2);
                lat_arm = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk("beat_expected", 64'(exp_data_q.size()), 64'd1);
                end else begin
                    chk("beat_data", m_data, exp_data_q.pop_front());
                    chk("beat_keep_last", 64'({m_keep, m_last}),
                        64'({exp_keep_q.pop_front(), exp_last_q.pop_front()}));
                    if (cur_beats == 0) cur_beat0 = m_data;
                    cur_beats++;
                    cur_bytes += $countones(m_keep);
                    if (m_last) begin
                        if (exp_len_q.size() != 0) begin
                            chk("frame_bytes", 64'(cur_bytes), 64'(exp_len_q.pop_front()));
                        end
                        cap_beats     = cur_beats;
                        cap_bytes     = cur_bytes;
                        cap_beat0     = cur_beat0;
                        cap_last_keep = m_keep;
                        cur_beats     = 0;
                        cur_bytes     = 0;
                    end
                end
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
            hold_ctl  = {m_keep, m_last, m_valid};
        end
    end

    initial begin
        // Reset state
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_keep_last", 64'({m_keep, m_last}), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_state", 64'(dut.fsm_dbg.state), 64'(ST_IDLE));
        chk("rst_byte_cnt", 64'(dut.fsm_dbg.byte_cnt), 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // ARP-like 6-beat frame with latency measurement
        rdy_mode = 0;
        fill_payload(48);
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 6, 8'hFF, -1, 48'h0, 1'b0, 1'b1);
        wait_drain();
        chk("arp_beat0", cap_beat0, 64'hFFFF_FFFF_FFFF_0102);
        chk("arp_beats", 64'(cap_beats), 64'd8);
        chk("arp_last_keep", 64'(cap_last_keep), 64'hFC);
        chk("arp_bytes", 64'(cap_bytes), 64'd62);

        // Single-beat payload, 4 bytes
        fill_payload(4);
        send_frame(48'h1122_3344_5566, 16'h0800, 1, 8'hF0, -1, 48'h0, 1'b0, 1'b0);
        wait_drain();
`ifdef MAC_TX_PAD_EN
        chk("short_beats", 64'(cap_beats), 64'd8);
        chk("short_last_keep", 64'(cap_last_keep), 64'hF0);
        chk("short_bytes", 64'(cap_bytes), 64'd60);
`else
        chk("short_beats", 64'(cap_beats), 64'd3);
        chk("short_last_keep", 64'(cap_last_keep), 64'hC0);
        chk("short_bytes", 64'(cap_bytes), 64'd18);
`endif

        // Non-contiguous last keep counts by its leading ones (n=2)
        fill_payload(10);
        send_frame(48'hA1A2_A3A4_A5A6, 16'h86DD, 2, 8'b1101_0110, -1, 48'h0, 1'b0, 1'b0);
        wait_drain();
`ifdef MAC_TX_PAD_EN
        chk("noncontig_bytes", 64'(cap_bytes), 64'd60);
`else
        chk("noncontig_bytes", 64'(cap_bytes), 64'd24);
`endif

        // Source MAC change mid-frame affects only the next frame
        fill_payload(32);
        send_frame(48'h0202_0202_0202, 16'h0800, 4, 8'hFF, 1, 48'h0A0B_0C0D_0E0F, 1'b0, 1'b0);
        exp_src = 48'h0A0B_0C0D_0E0F;
        wait_drain();
        chk("mac_old_frame", 64'(cap_beat0[15:0]), 64'h0102);
        fill_payload(16);
        send_frame(48'h0303_0303_0303, 16'h0800, 2, 8'hFF, -1, 48'h0, 1'b0, 1'b0);
        wait_drain();
        chk("mac_new_frame", 64'(cap_beat0[15:0]), 64'h0A0B);

        // Random frames, back-to-back, with random backpressure and gaps
        rdy_mode = 1;
        for (int f = 0; f < 100; f++) begin
            int         nb;
            logic [7:0] lk;
            nb = $urandom_range(1, 6);
            lk = rand_keep();
            fill_payload((nb - 1) * 8 + lead_ones(lk));
            send_frame({16'($urandom), 32'($urandom)}, 16'($urandom), nb, lk,
                       -1, 48'h0, 1'b1, 1'b0);
        end
        wait_drain();

        // Reset in DATA abandons the frame
        rdy_mode = 0;
        @(posedge i_clk); #1;
        mon_en  = 1'b0;
        s_user  = {16'd64, 48'h0404_0404_0404, 16'h0800};
        s_data  = 64'hDEAD_BEEF_0123_4567;
        s_keep  = 8'hFF;
        s_last  = 1'b0;
        s_valid = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("pre_rst_state", 64'(dut.fsm_dbg.state), 64'(ST_DATA));
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(m_valid), 64'd0);
        chk("midrst_data", m_data, 64'd0);
        chk("midrst_keep_last", 64'({m_keep, m_last}), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        exp_len_q.delete();
        exp_src = 48'h01_02_03_04_05_06;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        mon_en = 1'b1;
        fill_payload(19);
        send_frame(48'h0505_0505_0505, 16'h88B5, 3, 8'hE0, -1, 48'h0, 1'b0, 1'b0);
        wait_drain();
        chk("post_rst_beat0", cap_beat0, 64'h0505_0505_0505_0102);
`ifdef MAC_TX_PAD_EN
        chk("post_rst_bytes", 64'(cap_bytes), 64'd60);
`else
        chk("post_rst_bytes", 64'(cap_bytes), 64'd33);
`endif

        chk("frames_outstanding", 64'(exp_len_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
